// File: rtl/move_sort_collector.sv
// Move collector: stages one bundle of candidate moves, serializes set lanes, and keeps them in
// a register-based buffer sorted by MVV-LVA score. The best move is always in entry 0.
module move_sort_collector #(
   parameter int unsigned LANES = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned MW    = 18
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       newboard,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*MW-1:0]        in_moves,
   input  logic [LANES-1:0]           in_mask,
   input  logic                       col_done,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [MW-1:0]              out_move,
   output logic [5:0]                 out_score,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       drained
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

   // Reserved victim code 7 counts as no victim; attacker 7 already yields a zero low field.
   function automatic logic [5:0] score_of(input logic [MW-1:0] m);
      logic [2:0] att;
      logic [2:0] vic;
      att = m[5:3];
      vic = m[2:0];
      if (vic == 3'd7) begin
         vic = 3'd0;
      end
      return {vic, 3'd7 - att};
   endfunction

   logic [LANES*MW-1:0]       stg_data_q, stg_data_d;
   logic [LANES-1:0]          stg_mask_q, stg_mask_d;
   logic [DEPTH-1:0][MW-1:0]  ent_q, ent_d;
   logic [CW-1:0]             count_q, count_d;
   logic                      flag_q, flag_d;
   logic                      drained_q, drained_d;

   logic                      pop, ins, accept;
   logic [LW-1:0]             lane_idx;
   logic [MW-1:0]             ins_move;
   logic [5:0]                ins_score;
   logic [DEPTH-1:0][MW-1:0]  shifted;
   logic [CW-1:0]             n_rem;
   logic [DEPTH-1:0]          ge;

   assign in_ready  = (stg_mask_q == '0);
   assign out_valid = (count_q != '0);
   assign out_move  = ent_q[0];
   assign out_score = out_valid ? score_of(ent_q[0]) : 6'd0;
   assign count     = count_q;
   assign drained   = drained_q;

   always_comb begin
      pop    = out_valid && out_ready;
      accept = in_valid && in_ready;
      ins    = (stg_mask_q != '0) && ((count_q < CW'(DEPTH)) || pop);

      lane_idx = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (stg_mask_q[i]) begin
            lane_idx = LW'(i);
         end
      end
      ins_move  = stg_data_q[lane_idx*MW +: MW];
      ins_score = score_of(ins_move);

      // Entries past count are kept at zero, so shifting in zero on pop preserves that.
      shifted = ent_q;
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            shifted[i] = ent_q[i+1];
         end
         shifted[DEPTH-1] = '0;
      end
      n_rem = pop ? (count_q - CW'(1)) : count_q;

      // Insertion point sits after every remaining entry scoring >= the new move (stable ties).
      for (int i = 0; i < DEPTH; i++) begin
         ge[i] = (CW'(i) < n_rem) && (score_of(shifted[i]) >= ins_score);
      end

      ent_d = shifted;
      if (ins) begin
         ent_d[0] = ge[0] ? shifted[0] : ins_move;
         for (int i = 1; i < DEPTH; i++) begin
            if (ge[i]) begin
               ent_d[i] = shifted[i];
            end else if (ge[i-1]) begin
               ent_d[i] = ins_move;
            end else begin
               ent_d[i] = shifted[i-1];
            end
         end
      end

      count_d = count_q;
      if (ins && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !ins) begin
         count_d = count_q - CW'(1);
      end

      stg_data_d = stg_data_q;
      stg_mask_d = stg_mask_q;
      if (accept) begin
         stg_data_d = in_moves;
         stg_mask_d = in_mask;
      end else if (ins) begin
         stg_mask_d[lane_idx] = 1'b0;
      end

      flag_d    = flag_q | col_done;
      drained_d = flag_d && (stg_mask_d == '0) && (count_d == '0);

      if (newboard) begin
         stg_data_d = '0;
         stg_mask_d = '0;
         ent_d      = '0;
         count_d    = '0;
         flag_d     = 1'b0;
         drained_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stg_data_q <= '0;
         stg_mask_q <= '0;
         ent_q      <= '0;
         count_q    <= '0;
         flag_q     <= 1'b0;
         drained_q  <= 1'b0;
      end else begin
         stg_data_q <= stg_data_d;
         stg_mask_q <= stg_mask_d;
         ent_q      <= ent_d;
         count_q    <= count_d;
         flag_q     <= flag_d;
         drained_q  <= drained_d;
      end
   end

endmodule

// File: tb/tb_move_sort_collector.sv
// Bench for move_sort_collector: directed scenarios plus randomized traffic against a queue-based
// model of the staging lanes and the sorted buffer.
module tb_move_sort_collector;

   localparam int LANES = 8;
   localparam int DEPTH = 16;
   localparam int MW    = 18;

   logic                 clk = 1'b0;
   logic                 rst, newboard, in_valid, in_ready, col_done;
   logic                 out_valid, out_ready, drained;
   logic [LANES*MW-1:0]  in_moves;
   logic [LANES-1:0]     in_mask;
   logic [MW-1:0]        out_move;
   logic [5:0]           out_score;
   logic [4:0]           count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   move_sort_collector #(.LANES(LANES), .DEPTH(DEPTH), .MW(MW)) dut (
      .clk       (clk),
      .rst       (rst),
      .newboard  (newboard),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_moves  (in_moves),
      .in_mask   (in_mask),
      .col_done  (col_done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_move  (out_move),
      .out_score (out_score),
      .count     (count),
      .drained   (drained)
   );

   // Model: pending lanes still in staging, and the buffer kept as a sorted queue.
   logic [MW-1:0] mbuf[$];
   logic [MW-1:0] pq[$];
   bit            mflag;
   bit            mdrained;

   function automatic int sc(logic [MW-1:0] m);
      int a = int'(m[5:3]);
      int v = int'(m[2:0]);
      if (v == 7) v = 0;
      return v * 8 + (7 - a);
   endfunction

   function automatic logic [MW-1:0] mk(int f, int t, int a, int v);
      return {6'(f), 6'(t), 3'(a), 3'(v)};
   endfunction

   function automatic logic [MW-1:0] rnd_move();
      return mk($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(1, 6),
                $urandom_range(0, 6));
   endfunction

   function automatic logic [31:0] exp_vec();
      logic [MW-1:0] m;
      logic [5:0]    s;
      m = (mbuf.size() > 0) ? mbuf[0] : '0;
      s = (mbuf.size() > 0) ? 6'(sc(mbuf[0])) : 6'd0;
      return {pq.size() == 0, mbuf.size() > 0, m, s, 5'(mbuf.size()), mdrained};
   endfunction

   task automatic step();
      bit pop, ins, acc;
      logic [MW-1:0] m;
      int p;
      if (rst || newboard) begin
         mbuf.delete();
         pq.delete();
         mflag    = 0;
         mdrained = 0;
      end else begin
         pop = (mbuf.size() > 0) && out_ready;
         ins = (pq.size() > 0) && ((mbuf.size() < DEPTH) || pop);
         acc = in_valid && (pq.size() == 0);
         if (pop) void'(mbuf.pop_front());
         if (ins) begin
            m = pq.pop_front();
            p = 0;
            while (p < mbuf.size() && sc(mbuf[p]) >= sc(m)) p++;
            mbuf.insert(p, m);
         end
         if (acc) begin
            for (int l = 0; l < LANES; l++) begin
               if (in_mask[l]) pq.push_back(in_moves[l*MW +: MW]);
            end
         end
         if (col_done) mflag = 1;
         mdrained = mflag && (pq.size() == 0) && (mbuf.size() == 0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; newboard = 0; in_valid = 0; out_ready = 0; col_done = 0;
      in_mask = '0; in_moves = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
      n_tests++;
      if ({in_ready, out_valid, out_move, out_score, count, drained} !== {1'b1, 1'b0, 18'd0, 6'd0, 5'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got rdy=%0b vld=%0b mv=%0h sc=%0d cnt=%0d dr=%0b, want 1 0 0 0 0 0",
                  in_ready, out_valid, out_move, out_score, count, drained);
      end
   endtask

   task automatic test_two_captures();
      logic [MW-1:0] a, b;
      a = mk(1, 2, 2, 4);
      b = mk(3, 4, 1, 5);
      in_moves = '0;
      in_moves[0*MW +: MW] = a;
      in_moves[2*MW +: MW] = b;
      in_mask = 8'b0000_0101;
      in_valid = 1;
      step();
      in_valid = 0;
      n_tests++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL cap_ready1: got %0b want 0", in_ready);
      end
      step();
      n_tests++;
      if (in_ready !== 1'b0 || count !== 5'd1) begin
         n_fail++; $display("FAIL cap_ready2: got rdy=%0b cnt=%0d want 0 1", in_ready, count);
      end
      step();
      n_tests++;
      if (in_ready !== 1'b1 || count !== 5'd2 || out_score !== 6'd46 || out_move !== b) begin
         n_fail++;
         $display("FAIL cap_loaded: got rdy=%0b cnt=%0d sc=%0d mv=%0h want 1 2 46 %0h",
                  in_ready, count, out_score, out_move, b);
      end
      out_ready = 1;
      step();
      out_ready = 0;
      n_tests++;
      if (out_score !== 6'd37 || out_move !== a || count !== 5'd1) begin
         n_fail++;
         $display("FAIL cap_pop: got sc=%0d mv=%0h cnt=%0d want 37 %0h 1", out_score, out_move, count, a);
      end
      out_ready = 1;
      step();
      out_ready = 0;
      n_tests++;
      if (count !== 5'd0 || out_valid !== 1'b0 || out_score !== 6'd0) begin
         n_fail++;
         $display("FAIL cap_empty: got cnt=%0d vld=%0b sc=%0d want 0 0 0", count, out_valid, out_score);
      end
   endtask

   task automatic test_quiet_order();
      int att[3] = '{5, 1, 2};
      int want[3] = '{6, 5, 2};
      for (int k = 0; k < 3; k++) begin
         in_moves = '0;
         in_moves[0 +: MW] = mk(k, k + 8, att[k], 0);
         in_mask = 8'h01;
         in_valid = 1;
         step();
         in_valid = 0;
         step();
      end
      out_ready = 1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (out_score !== 6'(want[k])) begin
            n_fail++; $display("FAIL quiet_pop%0d: got %0d want %0d", k, out_score, want[k]);
         end
         step();
      end
      out_ready = 0;
      n_tests++;
      if (count !== 5'd0) begin
         n_fail++; $display("FAIL quiet_count: got %0d want 0", count);
      end
   endtask

   task automatic test_stable_tie();
      int from[2] = '{8, 16};
      for (int k = 0; k < 2; k++) begin
         in_moves = '0;
         in_moves[0 +: MW] = mk(from[k], 33, 4, 3);
         in_mask = 8'h01;
         in_valid = 1;
         step();
         in_valid = 0;
         step();
      end
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (out_move[17:12] !== 6'(from[k]) || out_score !== 6'd27) begin
            n_fail++;
            $display("FAIL tie_pop%0d: got from=%0h sc=%0d want %0h 27", k, out_move[17:12], out_score, from[k]);
         end
         out_ready = 1;
         step();
         out_ready = 0;
      end
   endtask

   task automatic test_full();
      int popped = 0;
      int guard  = 0;
      int prev   = 64;
      for (int b = 0; b < 3; b++) begin
         for (int l = 0; l < LANES; l++) in_moves[l*MW +: MW] = rnd_move();
         in_mask = 8'hFF;
         in_valid = 1;
         step();
         in_valid = 0;
         if (b < 2) for (int c = 0; c < LANES; c++) step();
      end
      for (int c = 0; c < 4; c++) begin
         step();
         n_tests++;
         if (in_ready !== 1'b0 || count !== 5'd16) begin
            n_fail++; $display("FAIL full_stall: got rdy=%0b cnt=%0d want 0 16", in_ready, count);
         end
      end
      for (int k = 0; k < LANES; k++) begin
         n_tests++;
         if (out_move !== mbuf[0]) begin
            n_fail++; $display("FAIL full_pop_ins: got %0h want %0h", out_move, mbuf[0]);
         end
         out_ready = 1;
         step();
         out_ready = 0;
         popped++;
         step();
         n_tests++;
         if (count !== 5'd16 || in_ready !== (k == LANES - 1) || pq.size() != LANES - 1 - k) begin
            n_fail++;
            $display("FAIL full_admit%0d: got cnt=%0d rdy=%0b want 16 %0b", k, count, in_ready, k == LANES - 1);
         end
      end
      out_ready = 1;
      while (out_valid && guard < 100) begin
         n_tests++;
         if (out_move !== mbuf[0] || int'(out_score) > prev) begin
            n_fail++;
            $display("FAIL full_drain: got mv=%0h sc=%0d want mv=%0h sc<=%0d", out_move, out_score, mbuf[0], prev);
         end
         prev = int'(out_score);
         step();
         popped++;
         guard++;
      end
      out_ready = 0;
      n_tests++;
      if (popped != 24 || count !== 5'd0) begin
         n_fail++; $display("FAIL full_total: got popped=%0d cnt=%0d want 24 0", popped, count);
      end
   endtask

   task automatic test_newboard();
      for (int l = 0; l < LANES; l++) in_moves[l*MW +: MW] = rnd_move();
      in_mask = 8'h07;
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (3) step();
      for (int l = 0; l < LANES; l++) in_moves[l*MW +: MW] = rnd_move();
      in_mask = 8'hC3;
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (2) step();
      n_tests++;
      if (count !== 5'd5 || dut.stg_mask_q !== 8'b1100_0000) begin
         n_fail++; $display("FAIL nb_setup: got cnt=%0d mask=%0h want 5 c0", count, dut.stg_mask_q);
      end
      newboard = 1; in_valid = 1; out_ready = 1; col_done = 1;
      step();
      idle_inputs();
      n_tests++;
      if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || drained !== 1'b0) begin
         n_fail++;
         $display("FAIL newboard: got cnt=%0d vld=%0b rdy=%0b dr=%0b want 0 0 1 0", count, out_valid, in_ready, drained);
      end
      step();
      n_tests++;
      if (count !== 5'd0 || drained !== 1'b0) begin
         n_fail++; $display("FAIL nb_after: got cnt=%0d dr=%0b want 0 0", count, drained);
      end
   endtask

   task automatic test_drained();
      for (int l = 0; l < LANES; l++) in_moves[l*MW +: MW] = rnd_move();
      in_mask = 8'h03;
      in_valid = 1;
      step();
      in_valid = 0;
      repeat (2) step();
      col_done = 1;
      step();
      col_done = 0;
      step();
      n_tests++;
      if (drained !== 1'b0 || count !== 5'd2) begin
         n_fail++; $display("FAIL drained_held: got dr=%0b cnt=%0d want 0 2", drained, count);
      end
      out_ready = 1;
      step();
      n_tests++;
      if (drained !== 1'b0 || count !== 5'd1) begin
         n_fail++; $display("FAIL drained_pop1: got dr=%0b cnt=%0d want 0 1", drained, count);
      end
      step();
      out_ready = 0;
      n_tests++;
      if (drained !== 1'b1 || count !== 5'd0) begin
         n_fail++; $display("FAIL drained_set: got dr=%0b cnt=%0d want 1 0", drained, count);
      end
      rst = 1;
      step();
      rst = 0;
      n_tests++;
      if (drained !== 1'b0) begin
         n_fail++; $display("FAIL drained_rst: got %0b want 0", drained);
      end
   endtask

   task automatic test_random();
      logic [31:0] want;
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         in_mask   = 8'($urandom());
         for (int l = 0; l < LANES; l++) in_moves[l*MW +: MW] = rnd_move();
         out_ready = ($urandom_range(0, 9) < 3);
         col_done  = ($urandom_range(0, 49) == 0);
         newboard  = ($urandom_range(0, 149) == 0);
         step();
         want = exp_vec();
         n_tests++;
         if ({in_ready, out_valid, out_move, out_score, count, drained} !== want) begin
            n_fail++;
            $display("FAIL random_c%0d: got %0h want %0h", c,
                     {in_ready, out_valid, out_move, out_score, count, drained}, want);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_two_captures();
      test_quiet_order();
      test_stable_tie();
      test_full();
      test_newboard();
      test_drained();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
